// File: rtl/stream_packet_generator.sv
// ----------------------------------------------------------------------------
// stream_packet_generator
//
// AXI-Stream test-packet source used to bring up a channel. After a start
// delay measured in ready-qualified cycles it emits packets made of one
// header beat followed by PKT_LEN payload beats in a selectable pattern,
// optionally separated by idle gaps. Backpressure is fully honoured: every
// stream output is a register, so TREADY never reaches TVALID/TDATA through
// combinational logic.
//
// Ports
//   clk               in   1           single clock, rising edge
//   reset             in   1           synchronous, active-low
//   enable            in   1           1 = run; 0 = finish packet then hold
//   mode              in   2           payload pattern, taken at each header
//   input_r_TVALID_0  out  1           stream valid
//   input_r_TREADY_0  in   1           stream ready from the sink
//   input_r_TDATA_0   out  DATA_WIDTH  stream data
//   input_r_TLAST_0   out  1           final beat of a packet
//   pkt_count         out  16          packets fully accepted (wraps)
//   busy              out  1           high while in HEADER, PAYLOAD or GAP
//   done              out  1           sticky once NUM_PKTS packets are sent
// ----------------------------------------------------------------------------
module stream_packet_generator #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PKT_LEN     = 216,
    parameter logic [31:0] HEADER_WORD = 32'h01000360,
    parameter int unsigned START_DELAY = 20000,
    parameter int unsigned NUM_PKTS    = 1,
    parameter int unsigned GAP_CYCLES  = 0,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1ACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    output logic                  input_r_TVALID_0,
    input  logic                  input_r_TREADY_0,
    output logic [DATA_WIDTH-1:0] input_r_TDATA_0,
    output logic                  input_r_TLAST_0,
    output logic [15:0]           pkt_count,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        WAIT_START,
        HEADER,
        PAYLOAD,
        GAP,
        DONE
    } state_t;

    localparam logic [15:0]           LAST_BEAT  = 16'(PKT_LEN);
    localparam logic [19:0]           DELAY_END  = 20'(START_DELAY);
    localparam logic [16:0]           PKT_TARGET = 17'(NUM_PKTS);
    localparam logic [7:0]            GAP_LAST   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
    localparam logic                  ZERO_LEN   = (PKT_LEN == 0);
    localparam logic                  CONTINUOUS = (NUM_PKTS == 0);
    localparam logic                  HAS_GAP    = (GAP_CYCLES != 0);
    localparam logic [DATA_WIDTH-1:0] HEADER_EXT = DATA_WIDTH'(HEADER_WORD);
    localparam logic [31:0]           LFSR_TAPS  = 32'h0040_0007;

    state_t                  state_q;
    logic                    rdy_q;
    logic [19:0]             delay_q;
    logic [15:0]             beat_q;
    logic [7:0]              gap_q;
    logic [31:0]             lfsr_q;
    logic [1:0]              mode_q;
    logic                    tvalid_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic                    tlast_q;
    logic [15:0]             pkt_count_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    xfer;
    logic [31:0]             lfsr_d;
    logic [15:0]             beat_d;
    logic [15:0]             pkt_count_d;
    logic                    last_pkt;

    // Builds one payload word for beat k. The 32-bit pattern is zero-extended
    // to the bus width; mode 3 inverts the 32-bit value only, so any upper
    // bits of a wider bus stay zero.
    function automatic logic [DATA_WIDTH-1:0] payloadWord(input logic [1:0]  sel,
                                                           input logic [15:0] k,
                                                           input logic [31:0] lfsr,
                                                           input logic [15:0] pkts);
        logic [31:0]           word;
        logic [DATA_WIDTH-1:0] wide;
        case (sel)
            2'd0:    word = {16'h0000, k};
            2'd1:    word = lfsr;
            2'd2:    word = {pkts, k};
            default: word = ~{16'h0000, k};
        endcase
        wide       = '0;
        wide[31:0] = word;
        return wide;
    endfunction

    // Next-value helpers shared by the state machine: the handshake, the
    // next LFSR value (left-shifting Galois form of x^32+x^22+x^2+x+1), the
    // next beat index and whether the packet now finishing is the last one.
    always_comb begin
        xfer        = tvalid_q & input_r_TREADY_0;
        lfsr_d      = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? LFSR_TAPS : 32'h0000_0000);
        beat_d      = beat_q + 16'd1;
        pkt_count_d = pkt_count_q + 16'd1;
        last_pkt    = !CONTINUOUS && (({1'b0, pkt_count_q} + 17'd1) == PKT_TARGET);
    end

    // Single registered state machine. Every stream output is loaded here one
    // beat ahead: when the current beat is accepted the next beat (or idle)
    // is computed and registered on the same edge, which gives back-to-back
    // beats with TREADY high and holds everything still while TREADY is low.
    // The end-of-packet branch is shared by header-only packets and by the
    // last payload beat, since both are marked by TLAST being accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= WAIT_START;
            rdy_q       <= 1'b0;
            delay_q     <= 20'd0;
            beat_q      <= 16'd0;
            gap_q       <= 8'd0;
            lfsr_q      <= LFSR_SEED;
            mode_q      <= 2'd0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            pkt_count_q <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rdy_q <= input_r_TREADY_0;
            case (state_q)
                WAIT_START: begin
                    if (enable && (delay_q == DELAY_END)) begin
                        state_q  <= HEADER;
                        busy_q   <= 1'b1;
                        tvalid_q <= 1'b1;
                        tdata_q  <= HEADER_EXT;
                        tlast_q  <= ZERO_LEN;
                    end else if (rdy_q && enable) begin
                        delay_q <= delay_q + 20'd1;
                    end
                end

                HEADER, PAYLOAD: begin
                    if (xfer) begin
                        if (tlast_q) begin
                            pkt_count_q <= pkt_count_d;
                            if ((state_q == PAYLOAD) && (mode_q == 2'd1)) begin
                                lfsr_q <= lfsr_d;
                            end
                            if (last_pkt) begin
                                state_q  <= DONE;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                            end else if (!enable) begin
                                state_q  <= WAIT_START;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                busy_q   <= 1'b0;
                            end else if (HAS_GAP) begin
                                state_q  <= GAP;
                                gap_q    <= 8'd0;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                            end else begin
                                state_q  <= HEADER;
                                tvalid_q <= 1'b1;
                                tdata_q  <= HEADER_EXT;
                                tlast_q  <= ZERO_LEN;
                            end
                        end else if (state_q == HEADER) begin
                            state_q <= PAYLOAD;
                            mode_q  <= mode;
                            beat_q  <= 16'd1;
                            tdata_q <= payloadWord(mode, 16'd1, lfsr_q, pkt_count_q);
                            tlast_q <= (LAST_BEAT == 16'd1);
                        end else begin
                            beat_q  <= beat_d;
                            if (mode_q == 2'd1) begin
                                lfsr_q <= lfsr_d;
                            end
                            tdata_q <= payloadWord(mode_q, beat_d, lfsr_d, pkt_count_q);
                            tlast_q <= (beat_d == LAST_BEAT);
                        end
                    end
                end

                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        if (enable) begin
                            state_q  <= HEADER;
                            tvalid_q <= 1'b1;
                            tdata_q  <= HEADER_EXT;
                            tlast_q  <= ZERO_LEN;
                        end else begin
                            state_q <= WAIT_START;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end

                DONE: begin
                    tvalid_q <= 1'b0;
                end

                default: begin
                    state_q  <= WAIT_START;
                    tvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign input_r_TVALID_0 = tvalid_q;
    assign input_r_TDATA_0  = tdata_q;
    assign input_r_TLAST_0  = tlast_q;
    assign pkt_count        = pkt_count_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_stream_packet_generator.sv
// ----------------------------------------------------------------------------
// tb_stream_packet_generator
//
// Five generator instances with different parameter sets share one clock.
// Each is held in reset until its own directed scenario runs, then its
// packets are collected beat by beat and compared with hand-derived values.
// ----------------------------------------------------------------------------
module tb_stream_packet_generator;

    localparam logic [31:0] HDR  = 32'h01000360;
    localparam logic [31:0] SEED = 32'hACE1ACE1;

    logic        clk = 1'b0;
    logic [4:0]  rstN;
    logic [4:0]  en;
    logic [4:0]  tready;
    logic [4:0]  tvalid;
    logic [4:0]  tlast;
    logic [4:0]  busy;
    logic [4:0]  done;
    logic [1:0]  md    [5];
    logic [31:0] tdata [5];
    logic [15:0] pcnt  [5];

    int checksRun    = 0;
    int checksPassed = 0;

    bit          monEn     = 1'b0;
    bit          stallPend = 1'b0;
    logic [31:0] stallData = '0;

    // Free-running 10-unit clock shared by all instances.
    always #5 clk = ~clk;

    stream_packet_generator dutDefault (
        .clk(clk), .reset(rstN[0]), .enable(en[0]), .mode(md[0]),
        .input_r_TVALID_0(tvalid[0]), .input_r_TREADY_0(tready[0]),
        .input_r_TDATA_0(tdata[0]), .input_r_TLAST_0(tlast[0]),
        .pkt_count(pcnt[0]), .busy(busy[0]), .done(done[0]));

    stream_packet_generator #(.START_DELAY(4), .PKT_LEN(8), .NUM_PKTS(2)) dutStall (
        .clk(clk), .reset(rstN[1]), .enable(en[1]), .mode(md[1]),
        .input_r_TVALID_0(tvalid[1]), .input_r_TREADY_0(tready[1]),
        .input_r_TDATA_0(tdata[1]), .input_r_TLAST_0(tlast[1]),
        .pkt_count(pcnt[1]), .busy(busy[1]), .done(done[1]));

    stream_packet_generator #(.START_DELAY(2), .PKT_LEN(4), .NUM_PKTS(3), .GAP_CYCLES(2)) dutGap (
        .clk(clk), .reset(rstN[2]), .enable(en[2]), .mode(md[2]),
        .input_r_TVALID_0(tvalid[2]), .input_r_TREADY_0(tready[2]),
        .input_r_TDATA_0(tdata[2]), .input_r_TLAST_0(tlast[2]),
        .pkt_count(pcnt[2]), .busy(busy[2]), .done(done[2]));

    stream_packet_generator #(.START_DELAY(0), .PKT_LEN(0), .NUM_PKTS(2)) dutHdrOnly (
        .clk(clk), .reset(rstN[3]), .enable(en[3]), .mode(md[3]),
        .input_r_TVALID_0(tvalid[3]), .input_r_TREADY_0(tready[3]),
        .input_r_TDATA_0(tdata[3]), .input_r_TLAST_0(tlast[3]),
        .pkt_count(pcnt[3]), .busy(busy[3]), .done(done[3]));

    stream_packet_generator #(.START_DELAY(3), .PKT_LEN(6), .NUM_PKTS(0), .GAP_CYCLES(1)) dutLfsr (
        .clk(clk), .reset(rstN[4]), .enable(en[4]), .mode(md[4]),
        .input_r_TVALID_0(tvalid[4]), .input_r_TREADY_0(tready[4]),
        .input_r_TDATA_0(tdata[4]), .input_r_TLAST_0(tlast[4]),
        .pkt_count(pcnt[4]), .busy(busy[4]), .done(done[4]));

    // Counts one comparison and reports it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checksRun++;
        if (got === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Releases one instance from reset with TREADY already high.
    task automatic applyStimulus(input int u, input logic [1:0] m);
        @(negedge clk);
        md[u]     = m;
        en[u]     = 1'b1;
        tready[u] = 1'b1;
        rstN[u]   = 1'b1;
    endtask

    // Reference LFSR step: feedback from bit 31 into taps 22, 2, 1 and 0.
    function automatic logic [31:0] lfsrStep(input logic [31:0] l);
        logic fb;
        fb = l[31];
        l  = l << 1;
        if (fb) begin
            l[22] = ~l[22];
            l[2]  = ~l[2];
            l[1]  = ~l[1];
            l[0]  = ~l[0];
        end
        return l;
    endfunction

    function automatic logic [31:0] expWord(input logic [1:0] m, input int k,
                                            input logic [15:0] pkt, input logic [31:0] lfsr);
        logic [15:0] k16;
        k16 = 16'(k);
        case (m)
            2'd0:    return {16'h0000, k16};
            2'd1:    return lfsr;
            2'd2:    return {pkt, k16};
            default: return 32'hFFFF_0000 | {16'h0000, ~k16};
        endcase
    endfunction

    // Waits for a beat that will transfer on the next rising edge. TREADY is
    // chosen on the falling edge, so data is sampled mid-cycle. waited counts
    // falling edges, i.e. the number of rising edges since the call.
    task automatic getBeat(input int u, input bit randReady, input int budget,
                           output logic [31:0] d, output logic l, output int waited);
        bit got;
        got    = 1'b0;
        waited = 0;
        d      = '0;
        l      = 1'b0;
        while (!got && waited < budget) begin
            @(negedge clk);
            waited++;
            tready[u] = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid[u] && tready[u]) begin
                got = 1'b1;
                d   = tdata[u];
                l   = tlast[u];
            end
        end
        if (!got) checkOutput($sformatf("u%0d_beat_timeout", u), 32'd0, 32'd1);
    endtask

    // Collects one packet and checks header, payload values, TLAST placement
    // and (with TREADY held high) the absence of bubbles. dropAfter drops
    // enable right after that payload beat is seen.
    task automatic collectPacket(input int u, input bit randReady, input int len,
                                 input logic [1:0] m, input logic [15:0] pktIdx,
                                 inout logic [31:0] lfsr, input int firstWait,
                                 input int dropAfter);
        logic [31:0] d;
        logic        l;
        int          w;
        getBeat(u, randReady, 30000, d, l, w);
        if (firstWait >= 0) checkOutput($sformatf("u%0d_p%0d_hdr_wait", u, pktIdx), 32'(w), 32'(firstWait));
        checkOutput($sformatf("u%0d_p%0d_hdr_data", u, pktIdx), d, HDR);
        checkOutput($sformatf("u%0d_p%0d_hdr_last", u, pktIdx), 32'(l), 32'(len == 0));
        for (int k = 1; k <= len; k++) begin
            getBeat(u, randReady, 64, d, l, w);
            if (!randReady) checkOutput($sformatf("u%0d_p%0d_k%0d_bubble", u, pktIdx, k), 32'(w), 32'd1);
            checkOutput($sformatf("u%0d_p%0d_k%0d_data", u, pktIdx, k), d, expWord(m, k, pktIdx, lfsr));
            checkOutput($sformatf("u%0d_p%0d_k%0d_last", u, pktIdx, k), 32'(l), 32'(k == len));
            if (m == 2'd1) lfsr = lfsrStep(lfsr);
            if (k == dropAfter) en[u] = 1'b0;
        end
    endtask

    // Confirms that TVALID stays low for a number of cycles.
    task automatic expectIdle(input int u, input int cycles, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tvalid[u]) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd0);
    endtask

    // While enabled, every cycle that ends with TVALID high and TREADY low on
    // the stall instance must be followed by the same data still valid.
    always @(negedge clk) begin
        #1;
        if (monEn) begin
            if (stallPend) begin
                checkOutput("stall_valid_held", 32'(tvalid[1]), 32'd1);
                checkOutput("stall_data_held", tdata[1], stallData);
            end
            stallPend = tvalid[1] & ~tready[1];
            stallData = tdata[1];
        end else begin
            stallPend = 1'b0;
        end
    end

    initial begin
        logic [31:0] lfsr;
        rstN   = '0;
        en     = '0;
        tready = '0;
        for (int i = 0; i < 5; i++) md[i] = 2'd0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_tvalid", 32'(tvalid[0]), 32'd0);
        checkOutput("rst_tlast", 32'(tlast[0]), 32'd0);
        checkOutput("rst_tdata", tdata[0], 32'd0);
        checkOutput("rst_pkt_count", 32'(pcnt[0]), 32'd0);
        checkOutput("rst_busy", 32'(busy[0]), 32'd0);
        checkOutput("rst_done", 32'(done[0]), 32'd0);

        $display("[TB] header-only packets");
        lfsr = SEED;
        applyStimulus(3, 2'd0);
        collectPacket(3, 1'b0, 0, 2'd0, 16'd0, lfsr, 1, -1);
        collectPacket(3, 1'b0, 0, 2'd0, 16'd1, lfsr, 1, -1);
        @(negedge clk);
        checkOutput("hdronly_pkt_count", 32'(pcnt[3]), 32'd2);
        checkOutput("hdronly_done", 32'(done[3]), 32'd1);
        checkOutput("hdronly_busy", 32'(busy[3]), 32'd0);
        expectIdle(3, 6, "hdronly_idle_after_done");

        $display("[TB] gaps and counter pattern");
        applyStimulus(2, 2'd2);
        collectPacket(2, 1'b0, 4, 2'd2, 16'd0, lfsr, 4, -1);
        collectPacket(2, 1'b0, 4, 2'd2, 16'd1, lfsr, 3, -1);
        collectPacket(2, 1'b0, 4, 2'd2, 16'd2, lfsr, 3, -1);
        @(negedge clk);
        checkOutput("gap_pkt_count", 32'(pcnt[2]), 32'd3);
        checkOutput("gap_done", 32'(done[2]), 32'd1);
        checkOutput("gap_busy", 32'(busy[2]), 32'd0);

        $display("[TB] random backpressure and mid-packet reset");
        applyStimulus(1, 2'd3);
        monEn = 1'b1;
        collectPacket(1, 1'b1, 8, 2'd3, 16'd0, lfsr, -1, -1);
        monEn = 1'b0;
        begin
            logic [31:0] d;
            logic        l;
            int          w;
            for (int k = 0; k <= 3; k++) getBeat(1, 1'b0, 64, d, l, w);
        end
        @(negedge clk);
        checkOutput("prerst_pkt_count", 32'(pcnt[1]), 32'd1);
        rstN[1] = 1'b0;
        @(negedge clk);
        checkOutput("midrst_tvalid", 32'(tvalid[1]), 32'd0);
        checkOutput("midrst_pkt_count", 32'(pcnt[1]), 32'd0);
        checkOutput("midrst_busy", 32'(busy[1]), 32'd0);
        rstN[1] = 1'b1;
        collectPacket(1, 1'b0, 8, 2'd3, 16'd0, lfsr, 6, -1);
        collectPacket(1, 1'b0, 8, 2'd3, 16'd1, lfsr, 1, -1);
        @(negedge clk);
        checkOutput("stall_pkt_count", 32'(pcnt[1]), 32'd2);
        checkOutput("stall_done", 32'(done[1]), 32'd1);

        $display("[TB] continuous LFSR with enable drop");
        lfsr = SEED;
        applyStimulus(4, 2'd1);
        collectPacket(4, 1'b0, 6, 2'd1, 16'd0, lfsr, 5, -1);
        collectPacket(4, 1'b0, 6, 2'd1, 16'd1, lfsr, 2, -1);
        collectPacket(4, 1'b0, 6, 2'd1, 16'd2, lfsr, 2, 2);
        expectIdle(4, 10, "lfsr_idle_after_disable");
        checkOutput("lfsr_done_never", 32'(done[4]), 32'd0);
        checkOutput("lfsr_pkt_count", 32'(pcnt[4]), 32'd3);
        checkOutput("lfsr_busy_idle", 32'(busy[4]), 32'd0);
        en[4] = 1'b1;
        collectPacket(4, 1'b0, 6, 2'd1, 16'd3, lfsr, 1, -1);

        $display("[TB] default parameters");
        applyStimulus(0, 2'd0);
        collectPacket(0, 1'b0, 216, 2'd0, 16'd0, lfsr, 20002, -1);
        @(negedge clk);
        checkOutput("dflt_done", 32'(done[0]), 32'd1);
        checkOutput("dflt_pkt_count", 32'(pcnt[0]), 32'd1);
        checkOutput("dflt_busy", 32'(busy[0]), 32'd0);
        expectIdle(0, 20, "dflt_idle_after_done");

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
